// File: rtl/sar_adc_seq.sv
// sar_adc_seq: multi-channel SAR ADC sequencer with per-channel oversampling and a valid/ready result stream.
// Optional continuous scanning is enabled by defining SAR_ADC_SEQ_CONT_EN (adds cont_i).
module sar_adc_seq #(
    parameter int RESOLUTION    = 8,
    parameter int NUM_CH        = 4,
    parameter int OSR_LOG2      = 0,
    parameter int SAMPLE_CYCLES = 2,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [NUM_CH-1:0]     ch_mask_i,
`ifdef SAR_ADC_SEQ_CONT_EN
    input  logic                  cont_i,
`endif
    input  logic                  comp_p_i,
    input  logic                  comp_n_i,
    output logic [CH_W-1:0]       ch_sel_o,
    output logic                  sample_o,
    output logic                  compare_o,
    output logic [RESOLUTION-2:0] dac_p_o,
    output logic [RESOLUTION-2:0] dac_n_o,
    output logic                  busy_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [RESOLUTION-1:0] out_data_o,
    output logic [CH_W-1:0]       out_ch_o
);
    localparam int ACC_W = RESOLUTION + OSR_LOG2;
    localparam int SMP_W = $clog2(SAMPLE_CYCLES + 1);
    localparam int CNT_W = OSR_LOG2 + 1;

    typedef enum logic [2:0] {IDLE, SELECT, SAMPLE, CONVERT, PUSH} state_e;

    state_e                state_q, state_d;
    logic [NUM_CH-1:0]     mask_q, mask_d;
    logic [CH_W-1:0]       ch_q, ch_d, ch_sel_q, ch_sel_d;
    logic [RESOLUTION-1:0] bit_q, bit_d, res_q, res_d;
    logic [RESOLUTION-2:0] dac_p_q, dac_p_d, dac_n_q, dac_n_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [SMP_W-1:0]      smp_q, smp_d;
    logic                  comp_q, b;
    logic [CH_W:0]         first, nxt;

    // Lowest enabled channel at or above 'from'; MSB flags that one exists.
    function automatic logic [CH_W:0] find_ch(input logic [NUM_CH-1:0] m, input int from);
        logic [CH_W:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (m[i] && i >= from) r = {1'b1, CH_W'(i)};
        return r;
    endfunction

    // 10 -> 1, 01 -> 0, 00/11 -> keep the last decisive comparator value.
    assign b = (comp_p_i & ~comp_n_i) | (~(comp_p_i ^ comp_n_i) & comp_q);

    assign ch_sel_o    = ch_sel_q;
    assign sample_o    = state_q == SAMPLE;
    assign compare_o   = state_q == CONVERT;
    assign dac_p_o     = dac_p_q;
    assign dac_n_o     = dac_n_q;
    assign busy_o      = state_q != IDLE;
    assign out_valid_o = state_q == PUSH;
    assign out_data_o  = acc_q[ACC_W-1:OSR_LOG2];
    assign out_ch_o    = ch_q;

    // Next-state: channel sequencing, sample timing, successive approximation and accumulation.
    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        ch_d     = ch_q;
        ch_sel_d = ch_sel_q;
        bit_d    = bit_q;
        res_d    = res_q;
        dac_p_d  = dac_p_q;
        dac_n_d  = dac_n_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        smp_d    = smp_q;
        first    = find_ch(mask_q, 0);
        nxt      = find_ch(mask_q, int'(ch_q) + 1);
        case (state_q)
            IDLE: if (start_i && |ch_mask_i) begin
                first    = find_ch(ch_mask_i, 0);
                mask_d   = ch_mask_i;
                ch_d     = first[CH_W-1:0];
                ch_sel_d = first[CH_W-1:0];
                state_d  = SELECT;
            end
            SELECT: state_d = SAMPLE;
            SAMPLE: begin
                bit_d = RESOLUTION'(1) << (RESOLUTION - 1);
                res_d = '0;
                smp_d = (smp_q == SMP_W'(SAMPLE_CYCLES - 1)) ? '0 : smp_q + 1'b1;
                state_d = (smp_q == SMP_W'(SAMPLE_CYCLES - 1)) ? CONVERT : SAMPLE;
            end
            CONVERT: begin
                res_d = res_q | (b ? bit_q : '0);
                if (bit_q != RESOLUTION'(1)) begin
                    dac_p_d = b ? dac_p_q ^ bit_q[RESOLUTION-1:1] : dac_p_q;
                    dac_n_d = b ? dac_n_q : dac_n_q ^ bit_q[RESOLUTION-1:1];
                    bit_d   = bit_q >> 1;
                end else begin
                    dac_p_d = '0;
                    dac_n_d = '0;
                    acc_d   = acc_q + ACC_W'(res_d);
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_d == CNT_W'(2 ** OSR_LOG2)) ? PUSH : SAMPLE;
                end
            end
            PUSH: if (out_ready_i) begin
                acc_d = '0;
                cnt_d = '0;
                if (nxt[CH_W]) begin
                    ch_d     = nxt[CH_W-1:0];
                    ch_sel_d = nxt[CH_W-1:0];
                    state_d  = SELECT;
`ifdef SAR_ADC_SEQ_CONT_EN
                end else if (cont_i) begin
                    ch_d     = first[CH_W-1:0];
                    ch_sel_d = first[CH_W-1:0];
                    state_d  = SELECT;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; comparator hold bit tracks the decoded value every cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            ch_q     <= '0;
            ch_sel_q <= '0;
            bit_q    <= '0;
            res_q    <= '0;
            dac_p_q  <= '0;
            dac_n_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            smp_q    <= '0;
            comp_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            ch_q     <= ch_d;
            ch_sel_q <= ch_sel_d;
            bit_q    <= bit_d;
            res_q    <= res_d;
            dac_p_q  <= dac_p_d;
            dac_n_q  <= dac_n_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            smp_q    <= smp_d;
            comp_q   <= b;
        end
    end
endmodule

// File: doc/sar_adc_seq.md
Name: sar_adc_seq

Overview:
- Multi-channel SAR ADC controller with a channel sequencer and oversampling.
- On start, scans every channel enabled in a latched mask in ascending index order. For each channel it runs 2^OSR_LOG2 SAR conversions, accumulates them, and emits the truncated average with its channel id on a valid/ready stream.
- Drives the analog mux select, sample switch, comparator enable and split P/N capacitive DAC. It is the successor of the single-channel SAR controller.

Parameters:
- RESOLUTION, 8, SAR bits per conversion (>=2).
- NUM_CH, 4, analog channels (>=1).
- OSR_LOG2, 0, log2 of conversions averaged per channel (0..4).
- SAMPLE_CYCLES, 2, cycles the sample switch stays closed per conversion (>=1).
- CH_W, $clog2(NUM_CH) (min 1), channel id width (derived localparam).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- start_i  in  1  start scan (accepted only in IDLE)
- ch_mask_i  in  NUM_CH  channel enable mask, latched on accepted start
- comp_p_i  in  1  comparator positive output
- comp_n_i  in  1  comparator negative output
- ch_sel_o  out  CH_W  analog mux select
- sample_o  out  1  sample switch closed
- compare_o  out  1  comparator enable
- dac_p_o  out  RESOLUTION-1  positive DAC control
- dac_n_o  out  RESOLUTION-1  negative DAC control
- busy_o  out  1  scan in progress
- out_valid_o  out  1  result valid
- out_ready_i  in  1  result accepted
- out_data_o  out  RESOLUTION  averaged result
- out_ch_o  out  CH_W  channel of out_data_o

Behaviour:
- Reset (rst_ni low at posedge clk_i, overrides everything, including mid-scan): state IDLE; all outputs 0; accumulator, mask and counters cleared; held comparator bit 0.
- Comparator decode:
  - {p,n}=10 -> 1; 01 -> 0.
  - 00/11 -> last valid value, held in a register updated every cycle.
- State IDLE:
  - start_i=1 with ch_mask_i!=0: latch mask, pick the lowest set channel, go to SELECT.
  - start_i=1 with mask 0: ignored.
  - start_i while not IDLE: ignored.
- State SELECT (1 cycle): ch_sel_o updated to the current channel; go to SAMPLE. ch_sel_o holds until the next SELECT.
- State SAMPLE (SAMPLE_CYCLES cycles):
  - sample_o=1; DACs 0.
  - On entry: bit mask = 1<<(RESOLUTION-1), conversion result = 0.
  - Then go to CONVERT.
- State CONVERT (exactly RESOLUTION cycles):
  - compare_o=1. Each cycle, with b = decoded comparator bit: result |= b ? mask : 0.
  - If mask != 1: when b=1, dac_p ^= mask>>1; otherwise dac_n ^= mask>>1. Then mask >>= 1.
  - On the mask==1 cycle: DACs cleared; the accumulator adds the final result (zero-extended, width RESOLUTION+OSR_LOG2).
  - If conversions for this channel < 2^OSR_LOG2, go to SAMPLE; otherwise go to PUSH.
- State PUSH:
  - out_valid_o=1; out_data_o = acc >> OSR_LOG2 (truncating); out_ch_o = current channel. Data and channel stay stable while valid and not ready.
  - On out_valid_o & out_ready_i: clear accumulator and conversion count. If a higher enabled channel exists, go to SELECT with it; otherwise go to IDLE.
  - Backpressure stalls the sequencer in PUSH; no conversion starts while a result is pending.
- busy_o=1 in every state except IDLE. Last handshake -> busy_o low the next cycle.
- Latency: start accepted at cycle 0 -> out_valid_o first high at cycle 1 + 1 + 2^OSR_LOG2*(SAMPLE_CYCLES+RESOLUTION).
- Invalid state encoding -> IDLE.

Optional Feature:
- Macro SAR_ADC_SEQ_CONT_EN.
  - Defined: adds input cont_i (1 bit). At the PUSH handshake of the highest enabled channel, if cont_i=1, wrap to the lowest enabled channel of the latched mask (SELECT) instead of going to IDLE. The mask is not re-latched.
  - Undefined: no cont_i port; the scan always ends in IDLE.

Test Plan:
- RESOLUTION=8, OSR_LOG2=0, mask=4'b0100, comparator model vin code 0xA5 (1 when the DAC-implied code <= vin) -> one output: data 0xA5, ch 2; busy_o low after the handshake; ch_sel_o=2.
- Comparator fixed 10, mask=4'b1011 -> three outputs in order: ch0, ch1, ch3, each 0xFF. Fixed 01 -> 0x00. During CONVERT dac_n_o stays 0 for fixed 10, dac_p_o stays 0 for fixed 01.
- Comparator pattern 10, 00, 11, 01, then 01 for the remaining bits -> bits 1,1,1,0,0,0,0,0 = 0xE0 (00/11 hold the last valid value).
- OSR_LOG2=2, four conversions yielding 0x10, 0x11, 0x12, 0x13 -> out_data_o 0x11 (sum 0x46 >> 2). Latency 2 + 4*(2+8) = 42 cycles from start.
- out_ready_i held low 20 cycles with mask=4'b0011 -> out_valid_o, data and ch stable for 20 cycles; no sample_o pulse until the handshake, then ch1 is converted.
- rst_ni low mid-CONVERT, plus start_i asserted while busy -> all outputs 0 the next cycle; the busy-time start has no effect. With SAR_ADC_SEQ_CONT_EN and cont_i=1, mask 4'b0101 -> output order 0, 2, 0, 2, ….
